// File: rtl/ecc_pkg.sv
// Shared SECDED Hamming(16,11) definitions used by the encoder and decoder.
// Holds the engine FSM state encoding and the codeword bit layout.
package ecc_pkg;

    localparam int CW_W  = 16;
    localparam int MSG_W = 11;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;
    localparam int P8 = 8;

    // Data bit j of the message lands at codeword position DATA_POS[j].
    localparam int DATA_POS [MSG_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LO   = 3'd1,
        ST_RD_HI   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_ENC     = 3'd4,
        ST_WR_LO   = 3'd5,
        ST_WR_HI   = 3'd6,
        ST_DONE    = 3'd7
    } enc_state_e;

endpackage

// File: rtl/hamming_parity.sv
// Combinational Hamming(16,11) codeword builder with overall-parity bit p0.
// Also reused by the decoder to recompute parity for its syndrome check.
module hamming_parity
    import ecc_pkg::*;
(
    input  logic [MSG_W-1:0] msg_i,
    output logic [CW_W-1:0]  cw_o
);

    logic [CW_W-1:0] cw;
    logic            p1, p2, p4, p8;

    always_comb begin
        cw = '0;
        for (int j = 0; j < MSG_W; j++) begin
            cw[DATA_POS[j]] = msg_i[j];
        end
        // Parity positions are never data positions, so scanning all of them is safe.
        p1 = 1'b0;
        p2 = 1'b0;
        p4 = 1'b0;
        p8 = 1'b0;
        for (int p = 1; p < CW_W; p++) begin
            if (p[0]) p1 = p1 ^ cw[p];
            if (p[1]) p2 = p2 ^ cw[p];
            if (p[2]) p4 = p4 ^ cw[p];
            if (p[3]) p8 = p8 ^ cw[p];
        end
        cw[P1] = p1;
        cw[P2] = p2;
        cw[P4] = p4;
        cw[P8] = p8;
        cw[P0] = ^cw[CW_W-1:1];
        cw_o   = cw;
    end

endmodule

// File: rtl/hamming_encoder.sv
// Memory-side SECDED encoder: reads N_MSG 11-bit messages as byte pairs,
// writes 16-bit codewords back through one byte port, 6 cycles per message.
module hamming_encoder
    import ecc_pkg::*;
#(
    parameter int N_MSG    = 30,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 64,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_we,
    output logic [7:0]    mem_wr_data,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] SRC_A   = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A   = AW'(DST_BASE);
    localparam logic [6:0]    LAST_IX = 7'(N_MSG - 1);

    enc_state_e         state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [7:0]         lo_q, lo_d;
    logic [2:0]         hi_q, hi_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic [CW_W-1:0]    enc_cw;
    logic [AW-1:0]      addr_q, addr_d;
    logic               we_q, we_d;
    logic [7:0]         wdat_q, wdat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    hamming_parity u_parity (
        .msg_i ({hi_q, lo_q}),
        .cw_o  (enc_cw)
    );

    function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] base,
                                                 input logic [6:0]    idx,
                                                 input logic          upper);
        logic [7:0] off;
        off       = {idx, upper};
        byte_addr = base + AW'(off);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cw_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cw_q    <= cw_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cw_d    = cw_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_RD_LO;
            ST_RD_LO:   state_d = ST_RD_HI;
            ST_RD_HI: begin
                lo_d    = mem_rd_data;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                hi_d    = mem_rd_data[2:0];
                state_d = ST_ENC;
            end
            ST_ENC: begin
                cw_d    = enc_cw;
                state_d = ST_WR_LO;
            end
            ST_WR_LO:   state_d = ST_WR_HI;
            ST_WR_HI: begin
                if (idx_q == LAST_IX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = ST_RD_LO;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they hold for the whole state.
    always_comb begin
        addr_d = '0;
        we_d   = 1'b0;
        wdat_d = '0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        unique case (state_d)
            ST_RD_LO: addr_d = byte_addr(SRC_A, idx_d, 1'b0);
            ST_RD_HI: addr_d = byte_addr(SRC_A, idx_d, 1'b1);
            ST_WR_LO: begin
                addr_d = byte_addr(DST_A, idx_d, 1'b0);
                we_d   = 1'b1;
                wdat_d = enc_cw[7:0];
            end
            ST_WR_HI: begin
                addr_d = byte_addr(DST_A, idx_d, 1'b1);
                we_d   = 1'b1;
                wdat_d = cw_q[15:8];
            end
            default: ;
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_we      = we_q;
    assign mem_wr_data = wdat_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed bench for hamming_encoder with a byte-wide memory model.
module tb_hamming_encoder;

    localparam int N   = 30;
    localparam int SRC = 0;
    localparam int DST = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_we;
    logic [7:0] mem_wr_data;
    logic       busy;
    logic       done;

    hamming_encoder #(.N_MSG(N), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_we     (mem_we),
        .mem_wr_data(mem_wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem    [256];
    logic [7:0]  ld_img [256];
    logic        ld_en = 1'b0;
    int          pe = 0;

    always @(posedge clk) begin
        pe <= pe + 1;
        if (ld_en) mem <= ld_img;
        else if (mem_we) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    int wr_cnt = 0;
    int bad_wr = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) begin
            wr_cnt = wr_cnt + 1;
            if (int'(mem_addr) < DST || int'(mem_addr) > DST + 2*N - 1) bad_wr = bad_wr + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    int errs = 0;
    int checks = 0;
    int e0 = 0;
    logic [10:0] msg [N];

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] cw;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_ref(input logic [10:0] d);
        logic [15:0] c;
        c        = '0;
        c[3]     = d[0];
        c[7:5]   = d[3:1];
        c[15:9]  = d[10:4];
        c[1]     = ^(c & 16'hAAAA);
        c[2]     = ^(c & 16'hCCCC);
        c[4]     = ^(c & 16'hF0F0);
        c[8]     = ^(c & 16'hFF00);
        c[0]     = ^c[15:1];
        return c;
    endfunction

    task automatic build_image();
        for (int a = 0; a < 256; a++) ld_img[a] = 8'hEE;
        for (int i = 0; i < N; i++) begin
            logic [7:0] lo, hi;
            if (i < 5) begin
                lo = vt[i].lo;
                hi = vt[i].hi;
            end else begin
                lo = 8'($urandom);
                hi = 8'($urandom);
            end
            ld_img[SRC + 2*i]     = lo;
            ld_img[SRC + 2*i + 1] = hi;
            msg[i] = {hi[2:0], lo};
        end
        @(negedge clk) ld_en = 1'b1;
        @(negedge clk) ld_en = 1'b0;
    endtask

    task automatic launch(input logic hold);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 e0 = pe;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_cycle", 32'(pe - e0 + 1), 32'(6*N + 1));
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("done_pulse_len", 32'(done), 32'd0);
    endtask

    task automatic verify_all(input string tag);
        for (int i = 0; i < N; i++) begin
            logic [15:0] got, exp;
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            exp = enc_ref(msg[i]);
            chk({tag, "_cw"}, 32'(got), 32'(exp));
            chk({tag, "_even"}, 32'(^got), 32'd0);
        end
    endtask

    initial begin
        int w0, b0, d0;
        bit found;
        logic [15:0] c5;

        vt[0] = '{lo: 8'h00, hi: 8'h00, cw: 16'h0000};
        vt[1] = '{lo: 8'hFF, hi: 8'hFF, cw: 16'hFFFF};
        vt[2] = '{lo: 8'h01, hi: 8'hF8, cw: 16'h000F};
        vt[3] = '{lo: 8'h00, hi: 8'hAC, cw: 16'h8117};
        vt[4] = '{lo: 8'h02, hi: 8'h00, cw: 16'h0033};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wr_data), 32'd0);
        reset = 1'b0;

        // Run 1: table vectors in slots 0..4, random messages after.
        build_image();
        w0 = wr_cnt; b0 = bad_wr; d0 = done_cnt;
        launch(1'b0);
        @(negedge clk);
        chk("rdlo_busy", 32'(busy), 32'd1);
        chk("rdlo_addr", 32'(mem_addr), 32'(SRC));
        wait_done();
        for (int i = 0; i < 5; i++) begin
            chk("vec_lo", 32'(mem[DST + 2*i]), 32'(vt[i].cw[7:0]));
            chk("vec_hi", 32'(mem[DST + 2*i + 1]), 32'(vt[i].cw[15:8]));
        end
        verify_all("run1");
        chk("run1_writes", 32'(wr_cnt - w0), 32'(2*N));
        chk("run1_bad_wr", 32'(bad_wr - b0), 32'd0);
        chk("run1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Run 2: a stray start pulse mid-run must not disturb timing.
        build_image();
        w0 = wr_cnt; d0 = done_cnt;
        launch(1'b0);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("midstart_busy", 32'(busy), 32'd1);
        wait_done();
        verify_all("run2");
        chk("run2_writes", 32'(wr_cnt - w0), 32'(2*N));
        chk("run2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Run 3: reset during WR_LO of message 5, then re-run from message 0.
        build_image();
        launch(1'b0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (mem_we && int'(mem_addr) == DST + 10) found = 1'b1;
        end
        chk("reach_wrlo5", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        chk("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        c5 = enc_ref(msg[5]);
        chk("partial_lo", 32'(mem[DST + 10]), 32'(c5[7:0]));
        chk("partial_hi", 32'(mem[DST + 11]), 32'h0000_00EE);
        chk("untouched_6", 32'(mem[DST + 12]), 32'h0000_00EE);
        w0 = wr_cnt;
        launch(1'b0);
        wait_done();
        verify_all("rerun");
        chk("rerun_writes", 32'(wr_cnt - w0), 32'(2*N));

        // Run 4: start held high through DONE relaunches after one IDLE cycle.
        launch(1'b1);
        wait_done();
        @(negedge clk);
        chk("relaunch_busy", 32'(busy), 32'd1);
        chk("relaunch_cycle", 32'(pe - e0 + 1), 32'(6*N + 3));
        chk("relaunch_addr", 32'(mem_addr), 32'(SRC));
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hamming_encoder.md
# hamming_encoder

Sequential SECDED Hamming(16,11) encoder, the transmit-side counterpart of the correction decoder. On `start` it walks a block of 11-bit messages in data memory, encodes each into a 16-bit codeword, and writes the codewords back to memory, all through a single byte-wide memory port. It signals completion with a one-cycle `done` pulse and sits beside the decoder as a memory-side engine.

## Interface
- `N_MSG`, 30: number of messages per run, 1..127.
- `SRC_BASE`, 0: byte address of the first message.
- `DST_BASE`, 64: byte address of the first codeword.
- `AW`, 8: memory byte-address width.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `mem_addr`  out  AW  byte address for the current read or write.
- `mem_rd_data`  in  8  read data, valid the cycle after the address is presented.
- `mem_we`  out  1  write strobe.
- `mem_wr_data`  out  8  write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Message i: low byte at `SRC_BASE+2i` holds d[7:0]. High byte at `SRC_BASE+2i+1` holds d[10:8] in bits [2:0]; bits [7:3] are ignored.
- Codeword bit positions 0..15:
  - p0 at position 0.
  - p1, p2, p4, p8 at positions 1, 2, 4, 8.
  - d0 at 3; d1..d3 at 5..7; d4..d10 at 9..15.
- Parity rules:
  - pk (k = 1, 2, 4, 8) = XOR of all data positions whose index has bit k set.
  - p0 = XOR of positions 1..15, so the codeword has even overall parity.
- Codeword write-back: cw[7:0] to `DST_BASE+2i`, cw[15:8] to `DST_BASE+2i+1`.
- Address arithmetic is modulo 2^AW; wrap-around is legal and not flagged.
- FSM states and transitions:
  - IDLE: go to RD_LO when `start`=1.
  - RD_LO: present the low address.
  - RD_HI: present the high address; capture the low byte.
  - WAIT_HI: capture the high byte.
  - ENC: register the codeword.
  - WR_LO: write cw[7:0].
  - WR_HI: write cw[15:8]. Go to DONE if i = N_MSG-1; otherwise increment i and go to RD_LO.
  - DONE: assert `done`, then go to IDLE.
- `start` while `busy` is ignored; no restart and no queueing.
- `reset` in any state returns the FSM to IDLE next edge. Any partially written codeword stays partial, and no further writes occur.
- Source and destination regions must not overlap; behaviour under overlap is undefined and not checked.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wr_data`=0, i=0, state IDLE.
- Outputs are registered; `mem_addr`, `mem_we` and `mem_wr_data` are valid for the whole cycle of their state.
- `mem_we`=1 only in WR_LO and WR_HI; `mem_wr_data`=0 otherwise.
- Each message takes 6 cycles.
- Run timing, with `start` sampled at edge 0:
  - RD_LO of message 0 at cycle 1.
  - Last WR_HI at cycle 6·N_MSG.
  - `done`=1 at cycle 6·N_MSG+1.
  - `busy` falls at cycle 6·N_MSG+2.
- A `start` held high through DONE launches a new run at cycle 6·N_MSG+3, i.e. one IDLE cycle first.

## Structure
- Shared package `ecc_pkg` holds:
  - the FSM state enum,
  - codeword position constants (P0, P1, P2, P4, P8 and the data position list),
  - codeword/message width constants (16, 11), shared with the decoder.
- One sub-module, `hamming_parity`: combinational, 11-bit message in, 16-bit codeword out. The decoder's syndrome check reuses it.

## Test plan
- Message 0x000 → codeword 0x0000: writes 0x00, 0x00.
- Message 0x7FF → codeword 0xFFFF: writes 0xFF, 0xFF.
- Message 0x001 → 0x000F, writes 0x0F then 0x00. Message 0x400 → 0x8117, writes 0x17 then 0x81.
- N_MSG=30 with random messages, high-byte bits [7:3] randomised:
  - every codeword matches the reference model and has even popcount,
  - `done` pulses exactly at cycle 181,
  - no writes fall outside `DST_BASE`..`DST_BASE+59`.
- `start` pulsed again mid-run → ignored, and `done` timing is unchanged.
- `reset` asserted in WR_LO of message 5:
  - next cycle shows IDLE, `busy`=0, `mem_we`=0, with no further writes;
  - a following `start` re-encodes from message 0.
